// File: rtl/load_store_unit.sv
// Load/store unit for an in-order RV32I memory stage.
// Accepts one load or store per request, checks funct3 legality and alignment,
// issues a single word-aligned data memory request with byte-lane mask, and
// returns sign/zero-extended load data to write-back.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_we    memory-stage instruction valid, 1 = store
//   req_funct3          RV32I width/sign encoding
//   req_addr/req_wdata  effective byte address, store data (rs2)
//   stall               hold upstream pipeline (combinational in IDLE)
//   dmem_req_*          data memory request channel (valid/ready)
//   dmem_we/wmask/addr/wdata  request fields, addr word-aligned
//   dmem_rsp_valid/dmem_rdata read response
//   load_data/load_valid      extended load result, one-cycle retire pulse
//   lsu_exc             one-cycle pulse on misaligned or illegal request
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_we,
    output logic [3:0]            dmem_wmask,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  lsu_exc
);

    localparam int unsigned NUM_LANES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  illegal_c;
    logic                  misaligned_c;
    logic                  accept_c;
    logic [7:0]            rd_byte_c;
    logic [15:0]           rd_half_c;
    logic [DATA_WIDTH-1:0] load_ext_c;

    // Request legality: illegal funct3 and natural-alignment checks
    always_comb begin
        illegal_c    = 1'b0;
        misaligned_c = 1'b0;
        if (req_we) begin
            illegal_c = (req_funct3 >= 3'd3);
            case (req_funct3[1:0])
                2'b01:   misaligned_c = req_addr[0];
                2'b10:   misaligned_c = (req_addr[1:0] != 2'b00);
                default: misaligned_c = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'd0, 3'd4: misaligned_c = 1'b0;
                3'd1, 3'd5: misaligned_c = req_addr[0];
                3'd2:       misaligned_c = (req_addr[1:0] != 2'b00);
                default:    illegal_c    = 1'b1;
            endcase
        end
    end

    assign accept_c = (state == IDLE) && req_valid && !illegal_c && !misaligned_c;

    // State register, latched request and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            funct3_q  <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            load_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept_c) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if ((state == WAIT) && dmem_rsp_valid) begin
                load_data <= load_ext_c;
            end
        end
    end

    // Next state and control outputs
    always_comb begin
        state_nxt      = state;
        stall          = 1'b0;
        dmem_req_valid = 1'b0;
        load_valid     = 1'b0;
        lsu_exc        = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (illegal_c || misaligned_c) begin
                        lsu_exc = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                stall          = 1'b1;
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    state_nxt = we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem_rsp_valid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                load_valid = !we_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields come only from latched values so they hold under backpressure
    assign dmem_we   = we_q;
    assign dmem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    // Store lane mask and replicated store data; loads drive an empty mask
    always_comb begin
        dmem_wmask = 4'b0000;
        dmem_wdata = wdata_q;
        if (we_q) begin
            case (funct3_q[1:0])
                2'b00: begin
                    dmem_wmask = 4'b0001 << addr_q[1:0];
                    dmem_wdata = {NUM_LANES{wdata_q[7:0]}};
                end
                2'b01: begin
                    dmem_wmask = 4'b0011 << addr_q[1:0];
                    dmem_wdata = {(NUM_LANES / 2){wdata_q[15:0]}};
                end
                default: dmem_wmask = 4'b1111;
            endcase
        end
    end

    // Load lane select and extension
    always_comb begin
        rd_byte_c = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
        rd_half_c = dmem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'd0:    load_ext_c = {{(DATA_WIDTH - 8){rd_byte_c[7]}}, rd_byte_c};
            3'd1:    load_ext_c = {{(DATA_WIDTH - 16){rd_half_c[15]}}, rd_half_c};
            3'd4:    load_ext_c = {{(DATA_WIDTH - 8){1'b0}}, rd_byte_c};
            3'd5:    load_ext_c = {{(DATA_WIDTH - 16){1'b0}}, rd_half_c};
            default: load_ext_c = dmem_rdata;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: table of single transactions with
// immediate memory handshake, plus backpressure and reset-abandon sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data;
    logic        load_valid;
    logic        lsu_exc;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall          (stall),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_wmask     (dmem_wmask),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .load_data      (load_data),
        .load_valid     (load_valid),
        .lsu_exc        (lsu_exc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exc;
        logic [31:0] ld;
        logic [31:0] daddr;
        logic [3:0]  wmask;
        logic [31:0] dwdata;
    } vec_t;

    localparam int unsigned NUM_VECS = 19;

    vec_t        vecs [NUM_VECS];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_ld   = 32'h0;

    function automatic vec_t mk(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic exc,
                                input logic [31:0] ld, input logic [3:0] wmask,
                                input logic [31:0] dwdata);
        vec_t v;
        v.we     = we;
        v.f3     = f3;
        v.addr   = addr;
        v.wdata  = wdata;
        v.rdata  = rdata;
        v.exc    = exc;
        v.ld     = ld;
        v.daddr  = {addr[31:2], 2'b00};
        v.wmask  = wmask;
        v.dwdata = dwdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Move to the drive point just after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One table transaction with ready/rsp held high; starts and ends at a drive point in IDLE
    task automatic run_vec(input int i, input vec_t v);
        req_valid      = 1'b1;
        req_we         = v.we;
        req_funct3     = v.f3;
        req_addr       = v.addr;
        req_wdata      = v.wdata;
        dmem_rdata     = v.rdata;
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_exc", i), 32'(lsu_exc), 32'(v.exc));
        chk($sformatf("v%0d_idle_stall", i), 32'(stall), 32'(!v.exc));
        chk($sformatf("v%0d_idle_dreq", i), 32'(dmem_req_valid), 32'd0);
        tick();
        if (v.exc) begin
            req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_exc_nodreq", i), 32'(dmem_req_valid), 32'd0);
            chk($sformatf("v%0d_exc_stall", i), 32'(stall), 32'd0);
            chk($sformatf("v%0d_exc_ld", i), load_data, exp_ld);
            tick();
        end else begin
            @(negedge clk);
            chk($sformatf("v%0d_req_valid", i), 32'(dmem_req_valid), 32'd1);
            chk($sformatf("v%0d_req_stall", i), 32'(stall), 32'd1);
            chk($sformatf("v%0d_req_addr", i), dmem_addr, v.daddr);
            chk($sformatf("v%0d_req_we", i), 32'(dmem_we), 32'(v.we));
            chk($sformatf("v%0d_req_wmask", i), 32'(dmem_wmask), 32'(v.wmask));
            if (v.we) chk($sformatf("v%0d_req_wdata", i), dmem_wdata, v.dwdata);
            tick();
            if (!v.we) begin
                @(negedge clk);
                chk($sformatf("v%0d_wait_stall", i), 32'(stall), 32'd1);
                chk($sformatf("v%0d_wait_lv", i), 32'(load_valid), 32'd0);
                tick();
                exp_ld = v.ld;
            end
            @(negedge clk);
            chk($sformatf("v%0d_done_lv", i), 32'(load_valid), 32'(!v.we));
            chk($sformatf("v%0d_done_stall", i), 32'(stall), 32'd0);
            chk($sformatf("v%0d_done_ld", i), load_data, exp_ld);
            tick();
            req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_after_dreq", i), 32'(dmem_req_valid), 32'd0);
            chk($sformatf("v%0d_after_lv", i), 32'(load_valid), 32'd0);
            chk($sformatf("v%0d_after_stall", i), 32'(stall), 32'd0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Loads: expected results are hand-extracted from the listed rdata lanes
        vecs[0]  = mk(1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0);
        vecs[1]  = mk(1'b0, 3'd5, 32'h0000_0102, 32'h0, 32'h8001_0000, 1'b0, 32'h0000_8001, 4'b0000, 32'h0);
        vecs[2]  = mk(1'b0, 3'd1, 32'h0000_0102, 32'h0, 32'h8001_0000, 1'b0, 32'hFFFF_8001, 4'b0000, 32'h0);
        vecs[3]  = mk(1'b0, 3'd4, 32'h0000_0101, 32'h0, 32'h80FF_1234, 1'b0, 32'h0000_0012, 4'b0000, 32'h0);
        vecs[4]  = mk(1'b0, 3'd2, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4'b0000, 32'h0);
        vecs[5]  = mk(1'b0, 3'd0, 32'h0000_0100, 32'h0, 32'hFFFF_FF7F, 1'b0, 32'h0000_007F, 4'b0000, 32'h0);
        vecs[6]  = mk(1'b0, 3'd4, 32'h0000_0102, 32'h0, 32'h0080_0000, 1'b0, 32'h0000_0080, 4'b0000, 32'h0);
        vecs[7]  = mk(1'b0, 3'd1, 32'h0000_0100, 32'h0, 32'h1234_F00D, 1'b0, 32'hFFFF_F00D, 4'b0000, 32'h0);
        // Stores
        vecs[8]  = mk(1'b1, 3'd0, 32'h0000_0201, 32'h0000_00AB, 32'h0, 1'b0, 32'h0, 4'b0010, 32'hABAB_ABAB);
        vecs[9]  = mk(1'b1, 3'd1, 32'h0000_0202, 32'h1234_CAFE, 32'h0, 1'b0, 32'h0, 4'b1100, 32'hCAFE_CAFE);
        vecs[10] = mk(1'b1, 3'd2, 32'h0000_030C, 32'h0123_4567, 32'h0, 1'b0, 32'h0, 4'b1111, 32'h0123_4567);
        vecs[11] = mk(1'b1, 3'd0, 32'h0000_0003, 32'h1234_565A, 32'h0, 1'b0, 32'h0, 4'b1000, 32'h5A5A_5A5A);
        // Exceptions: misaligned and illegal funct3
        vecs[12] = mk(1'b0, 3'd2, 32'h0000_0102, 32'h0, 32'h1111_1111, 1'b1, 32'h0, 4'b0000, 32'h0);
        vecs[13] = mk(1'b0, 3'd3, 32'h0000_0100, 32'h0, 32'h1111_1111, 1'b1, 32'h0, 4'b0000, 32'h0);
        vecs[14] = mk(1'b0, 3'd1, 32'h0000_0101, 32'h0, 32'h1111_1111, 1'b1, 32'h0, 4'b0000, 32'h0);
        vecs[15] = mk(1'b1, 3'd2, 32'h0000_0206, 32'h5, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
        vecs[16] = mk(1'b1, 3'd3, 32'h0000_0200, 32'h5, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
        vecs[17] = mk(1'b0, 3'd6, 32'h0000_0100, 32'h0, 32'h1111_1111, 1'b1, 32'h0, 4'b0000, 32'h0);
        vecs[18] = mk(1'b1, 3'd1, 32'h0000_0203, 32'h5, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);

        rst            = 1'b1;
        req_valid      = 1'b0;
        req_we         = 1'b0;
        req_funct3     = 3'd0;
        req_addr       = 32'h0;
        req_wdata      = 32'h0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dreq", 32'(dmem_req_valid), 32'd0);
        chk("rst_lv", 32'(load_valid), 32'd0);
        chk("rst_exc", 32'(lsu_exc), 32'd0);
        chk("rst_ld", load_data, 32'h0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < int'(NUM_VECS); i++) begin
            run_vec(i, vecs[i]);
        end

        // Load with request backpressure, stray rsp during REQ, then late response
        req_valid      = 1'b1;
        req_we         = 1'b0;
        req_funct3     = 3'd5;
        req_addr       = 32'h0000_010A;
        dmem_rdata     = 32'hBEEF_1234;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("bp_idle_stall", 32'(stall), 32'd1);
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_req%0d_valid", c), 32'(dmem_req_valid), 32'd1);
            chk($sformatf("bp_req%0d_addr", c), dmem_addr, 32'h0000_0108);
            chk($sformatf("bp_req%0d_we", c), 32'(dmem_we), 32'd0);
            chk($sformatf("bp_req%0d_wmask", c), 32'(dmem_wmask), 32'd0);
            chk($sformatf("bp_req%0d_stall", c), 32'(stall), 32'd1);
            chk($sformatf("bp_req%0d_lv", c), 32'(load_valid), 32'd0);
            tick();
        end
        dmem_req_ready = 1'b1;
        @(negedge clk);
        chk("bp_req_accept_valid", 32'(dmem_req_valid), 32'd1);
        tick();
        dmem_rsp_valid = 1'b0;
        dmem_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp_wait%0d_stall", c), 32'(stall), 32'd1);
            chk($sformatf("bp_wait%0d_dreq", c), 32'(dmem_req_valid), 32'd0);
            chk($sformatf("bp_wait%0d_lv", c), 32'(load_valid), 32'd0);
            tick();
        end
        dmem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("bp_rsp_stall", 32'(stall), 32'd1);
        tick();
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("bp_done_lv", 32'(load_valid), 32'd1);
        chk("bp_done_ld", load_data, 32'h0000_BEEF);
        chk("bp_done_stall", 32'(stall), 32'd0);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp_after_lv", 32'(load_valid), 32'd0);
        tick();

        // Store with backpressure: fields must hold until accepted
        req_valid      = 1'b1;
        req_we         = 1'b1;
        req_funct3     = 3'd1;
        req_addr       = 32'h0000_0206;
        req_wdata      = 32'h0000_BEEF;
        dmem_req_ready = 1'b0;
        @(negedge clk);
        tick();
        req_valid = 1'b0;
        req_wdata = 32'h0;
        req_addr  = 32'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("sbp%0d_addr", c), dmem_addr, 32'h0000_0204);
            chk($sformatf("sbp%0d_wmask", c), 32'(dmem_wmask), 32'(4'b1100));
            chk($sformatf("sbp%0d_wdata", c), dmem_wdata, 32'hBEEF_BEEF);
            chk($sformatf("sbp%0d_we", c), 32'(dmem_we), 32'd1);
            tick();
        end
        dmem_req_ready = 1'b1;
        @(negedge clk);
        chk("sbp_accept_valid", 32'(dmem_req_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("sbp_done_lv", 32'(load_valid), 32'd0);
        chk("sbp_done_stall", 32'(stall), 32'd0);
        chk("sbp_done_ld", load_data, 32'h0000_BEEF);
        tick();

        // Reset while waiting for a load response; the late response must be dropped
        req_valid      = 1'b1;
        req_we         = 1'b0;
        req_funct3     = 3'd0;
        req_addr       = 32'h0000_0100;
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("rw_req_valid", 32'(dmem_req_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("rw_wait_stall", 32'(stall), 32'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst            = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h1122_3344;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rw%0d_ld", c), load_data, 32'h0);
            chk($sformatf("rw%0d_lv", c), 32'(load_valid), 32'd0);
            chk($sformatf("rw%0d_stall", c), 32'(stall), 32'd0);
            chk($sformatf("rw%0d_dreq", c), 32'(dmem_req_valid), 32'd0);
            tick();
        end
        dmem_rsp_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
